// File: rtl/clr_req_conditioner.sv
// Purpose : conditions three asynchronous clear requests into clean, stretched, single-domain clear pulses,
//           with the 2-bit data path delayed to stay aligned with the clears.
// Latency : req sampled at edge N -> clr high after edge N+2; data_src at edge M -> data_out after edge M+2.
// Backpressure: none; the block free-runs every cycle and never stalls.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset; forces every clear high for STRETCH_LEN cycles after release
//   req1..req3     asynchronous clear requests, rising edge triggers a pulse
//   data_src[1:0]  data synchronous to clk
//   clr1..clr3     registered clear lines, high exactly while the channel is stretching
//   data_out[1:0]  data_src through a 3-stage pipeline, never gated
//   busy           registered OR of "channel not idle", one cycle behind the channel state
//
// Build option: define CLR_HOLDOFF_EN to add the HOLDOFF dead time (HOLDOFF_LEN cycles) after every pulse,
// with one pending request remembered per channel during that time.
module clr_req_conditioner #(
   parameter int unsigned STRETCH_LEN = 4,
   parameter int unsigned HOLDOFF_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req1,
   input  logic       req2,
   input  logic       req3,
   input  logic [1:0] data_src,
   output logic       clr1,
   output logic       clr2,
   output logic       clr3,
   output logic [1:0] data_out,
   output logic       busy
);

   if (STRETCH_LEN < 1 || STRETCH_LEN > 255) begin : g_bad_stretch
      $error("STRETCH_LEN must be in 1..255");
   end
   if (HOLDOFF_LEN < 1 || HOLDOFF_LEN > 255) begin : g_bad_holdoff
      $error("HOLDOFF_LEN must be in 1..255");
   end

`ifdef CLR_HOLDOFF_EN
   typedef enum logic [1:0] {ST_IDLE, ST_STRETCH, ST_HOLDOFF} state_t;
   localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_LEN - 1);
`else
   typedef enum logic [1:0] {ST_IDLE, ST_STRETCH} state_t;
`endif

   localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_LEN - 1);

   logic [2:0] req_vec;
   logic [2:0] s1_q;
   logic [2:0] s2_q;
   logic [2:0] s3_q;
   logic [2:0] rise;
   logic [2:0] clr_vec;
   logic [2:0] nonidle;
   logic       busy_q;
   logic [1:0] dat0_q;
   logic [1:0] dat1_q;
   logic [1:0] dat2_q;

   assign req_vec = {req3, req2, req1};

   // s1/s2 form the synchroniser; s3 only exists to detect the rising edge of s2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= req_vec;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      state_t     state_q;
      state_t     state_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic       clr_q;
`ifdef CLR_HOLDOFF_EN
      logic       pend_q;
      logic       pend_d;
`endif

      // Reset parks the channel mid-stretch so the downstream register is cleared out of reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_STRETCH;
            cnt_q   <= STRETCH_LOAD;
            clr_q   <= 1'b1;
`ifdef CLR_HOLDOFF_EN
            pend_q  <= 1'b0;
`endif
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= (state_d == ST_STRETCH);
`ifdef CLR_HOLDOFF_EN
            pend_q  <= pend_d;
`endif
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
`ifdef CLR_HOLDOFF_EN
         pend_d  = pend_q;
`endif
         case (state_q)
            ST_IDLE: begin
               if (rise[ch]) begin
                  state_d = ST_STRETCH;
                  cnt_d   = STRETCH_LOAD;
               end
            end
            ST_STRETCH: begin
               // A new edge restarts the full width rather than adding to it.
               if (rise[ch]) begin
                  cnt_d = STRETCH_LOAD;
               end else if (cnt_q == 8'd0) begin
`ifdef CLR_HOLDOFF_EN
                  state_d = ST_HOLDOFF;
                  cnt_d   = HOLDOFF_LOAD;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
`ifdef CLR_HOLDOFF_EN
            ST_HOLDOFF: begin
               // An edge on the final holdoff cycle still counts as pending.
               if (cnt_q == 8'd0) begin
                  pend_d = 1'b0;
                  if (pend_q || rise[ch]) begin
                     state_d = ST_STRETCH;
                     cnt_d   = STRETCH_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
                  if (rise[ch]) begin
                     pend_d = 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      assign clr_vec[ch] = clr_q;
      assign nonidle[ch] = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b1;
      end else begin
         busy_q <= |nonidle;
      end
   end

   // Three stages: one per synchroniser flop plus the FSM/clear register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat0_q <= '0;
         dat1_q <= '0;
         dat2_q <= '0;
      end else begin
         dat0_q <= data_src;
         dat1_q <= dat0_q;
         dat2_q <= dat1_q;
      end
   end

   assign clr1     = clr_vec[0];
   assign clr2     = clr_vec[1];
   assign clr3     = clr_vec[2];
   assign data_out = dat2_q;
   assign busy     = busy_q;

endmodule
